iot_pio_gen2: RTL

//  Parametrised Avalon-MM parallel I/O port, successor to the fixed 4-bit PIO in the IOT system.
//  - Per-bit direction control, input synchronisers and edge capture with a maskable IRQ.
//  - Sits on the IOT Avalon interconnect as a slave; drives board pins through out_port/oe.

---
 rtl/iot_pio_gen2.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/iot_pio_gen2.sv
// -----------------------------------------------------------------------------
// iot_pio_gen2 -- parametrised Avalon-MM parallel I/O port
//
// Per-bit direction control, multi-flop input synchroniser, edge capture with
// write-1-clear and a maskable level interrupt. It replaces the fixed 4-bit PIO.
//
// Parameters
//   WIDTH        number of I/O bits (1..32)
//   RESET_VALUE  value loaded into data_out at reset
//   EDGE_TYPE    0 rising, 1 falling, 2 any edge
//   SYNC_STAGES  input synchroniser depth (2..4)
//
// Ports
//   clk         system clock
//   reset_n     asynchronous, active-low reset
//   address     register word address (3 bits)
//   chipselect  slave select
//   write_n     active-low write strobe
//   writedata   write data, bits [WIDTH-1:0] used
//   in_port     asynchronous pin inputs
//   out_port    data_out register
//   oe          direction register, 1 = output enable
//   readdata    registered read data, upper bits zero
//   irq         level interrupt, |(edgecap & mask)
//
// Register map
//   0 DATA     R: synchronised pins, W: data_out
//   1 DIR      R/W
//   2 IRQMASK  R/W
//   3 EDGECAP  R: captured edges, W: clear bits written 1
//   4 OUTSET   W: data_out |= wd  (only with IOT_PIO_BITSET_EN, reads 0)
//   5 OUTCLR   W: data_out &= ~wd (only with IOT_PIO_BITSET_EN, reads 0)
//   6,7        read 0, writes ignored
//
// Optional feature macro: IOT_PIO_BITSET_EN enables OUTSET/OUTCLR. Without
// it, addresses 4 and 5 behave as unmapped.
// -----------------------------------------------------------------------------
module iot_pio_gen2 #(
  parameter int               WIDTH       = 4,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter int               EDGE_TYPE   = 0,
  parameter int               SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] out_port,
  output logic [WIDTH-1:0] oe,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam logic [2:0] ADDR_DATA    = 3'd0;
  localparam logic [2:0] ADDR_DIR     = 3'd1;
  localparam logic [2:0] ADDR_IRQMASK = 3'd2;
  localparam logic [2:0] ADDR_EDGECAP = 3'd3;
`ifdef IOT_PIO_BITSET_EN
  localparam logic [2:0] ADDR_OUTSET  = 3'd4;
  localparam logic [2:0] ADDR_OUTCLR  = 3'd5;
`endif

  // The arm counter must outlast the time it takes the synchroniser and the
  // prev register to fill, otherwise a pin held high through reset looks
  // like a rising edge.
  localparam int ARM_MAX = SYNC_STAGES + 1;
  localparam int ARM_W   = $clog2(ARM_MAX + 1);

  logic [WIDTH-1:0] r_sync [SYNC_STAGES];
  logic [WIDTH-1:0] r_prev;
  logic [ARM_W-1:0] r_arm;
  logic [WIDTH-1:0] r_data_out;
  logic [WIDTH-1:0] r_dir;
  logic [WIDTH-1:0] r_mask;
  logic [WIDTH-1:0] r_edgecap;
  logic [31:0]      r_readdata;

  logic             w_wr;
  logic [WIDTH-1:0] w_wd;
  logic [WIDTH-1:0] w_sync;
  logic             w_armed;
  logic [WIDTH-1:0] w_rise;
  logic [WIDTH-1:0] w_fall;
  logic [WIDTH-1:0] w_edge;
  logic [WIDTH-1:0] w_clr;
  logic [WIDTH-1:0] w_data_out_nxt;
  logic [31:0]      w_rd_nxt;
  logic             w_unused;

  assign w_wr     = chipselect & ~write_n;
  assign w_wd     = writedata[WIDTH-1:0];
  assign w_unused = &{1'b0, writedata};

  // Input synchroniser
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
      r_prev <= '0;
    end else begin
      r_sync[0] <= in_port;
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
      r_prev <= w_sync;
    end
  end

  assign w_sync = r_sync[SYNC_STAGES-1];

  // Arm counter: saturates at ARM_MAX, restarts on every reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_arm <= '0;
    end else if (!w_armed) begin
      r_arm <= r_arm + 1'b1;
    end
  end

  assign w_armed = (r_arm == ARM_W'(ARM_MAX));

  // Edge detection
  assign w_rise = w_sync & ~r_prev;
  assign w_fall = ~w_sync & r_prev;

  always_comb begin
    w_edge = '0;
    if (w_armed) begin
      case (EDGE_TYPE)
        1:       w_edge = w_fall;
        2:       w_edge = w_rise | w_fall;
        default: w_edge = w_rise;
      endcase
    end
  end

  assign w_clr = (w_wr && address == ADDR_EDGECAP) ? w_wd : '0;

  // data_out update, including the optional atomic set/clear
  always_comb begin
    w_data_out_nxt = r_data_out;
    if (w_wr) begin
      case (address)
        ADDR_DATA:   w_data_out_nxt = w_wd;
`ifdef IOT_PIO_BITSET_EN
        ADDR_OUTSET: w_data_out_nxt = r_data_out | w_wd;
        ADDR_OUTCLR: w_data_out_nxt = r_data_out & ~w_wd;
`endif
        default:     w_data_out_nxt = r_data_out;
      endcase
    end
  end

  // Read mux; OUTSET/OUTCLR and unmapped addresses fall to zero
  always_comb begin
    w_rd_nxt = '0;
    case (address)
      ADDR_DATA:    w_rd_nxt = 32'(w_sync);
      ADDR_DIR:     w_rd_nxt = 32'(r_dir);
      ADDR_IRQMASK: w_rd_nxt = 32'(r_mask);
      ADDR_EDGECAP: w_rd_nxt = 32'(r_edgecap);
      default:      w_rd_nxt = '0;
    endcase
  end

  // Register file
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_data_out <= RESET_VALUE;
      r_dir      <= '0;
      r_mask     <= '0;
      r_edgecap  <= '0;
      r_readdata <= '0;
    end else begin
      r_data_out <= w_data_out_nxt;
      if (w_wr && address == ADDR_DIR)     r_dir  <= w_wd;
      if (w_wr && address == ADDR_IRQMASK) r_mask <= w_wd;
      // A new edge overrides a simultaneous write-1-clear on the same bit
      r_edgecap  <= (r_edgecap & ~w_clr) | w_edge;
      r_readdata <= w_rd_nxt;
    end
  end

  assign out_port = r_data_out;
  assign oe       = r_dir;
  assign readdata = r_readdata;
  // Derived only from registers so it drops right after a clear or mask write
  assign irq      = |(r_edgecap & r_mask);

endmodule
